// File: rtl/shifter_video_ste_if.sv
// Video word bus between the MMU/video DMA (master) and the pixel shifter (slave).
interface shifter_video_ste_if #(
    parameter int WORD_W = 16
);
    logic              pixClkEn;
    logic              DE;
    logic              LOAD;
    logic [WORD_W-1:0] DIN;

    modport master (
        output pixClkEn,
        output DE,
        output LOAD,
        output DIN
    );

    modport slave (
        input pixClkEn,
        input DE,
        input LOAD,
        input DIN
    );
endinterface

// File: rtl/shifter_video_ste.sv
// STe-style bitplane shifter: plane latch bank, 32-bit shift windows, fine hscroll.
// Optional saturating underflow counter under SHIFTER_UNDERFLOW_STAT_EN.
//
// state | meaning
// IDLE  | no group on display; pixel counter held at 0, windows drain
// RUN   | groups transferred every WORD_W pixels; underflow if none ready
module shifter_video_ste #(
    parameter int PLANES   = 4,
    parameter int WORD_W   = 16,
    parameter int SCROLL_W = 4
) (
    input  logic                clk32,
    input  logic                nReset,
    shifter_video_ste_if.slave  bus,
    input  logic [1:0]          rez,
    input  logic                monocolor,
    input  logic [SCROLL_W-1:0] hscroll,
    output logic                Reload,
    output logic [PLANES-1:0]   color_index,
    output logic [7:0]          underflow_cnt
);

    localparam int WCNT_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int WPG_MID = (PLANES / 2 > 1) ? PLANES / 2 : 1;
    localparam logic [SCROLL_W-1:0] MAXIDX = SCROLL_W'(WORD_W - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_load_q;
    logic [WORD_W-1:0]   r_latch [PLANES];
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_grp_rdy;
    logic [SCROLL_W-1:0] r_pcnt;
    logic [SCROLL_W-1:0] r_scroll_q;
    logic [2*WORD_W-1:0] r_win [PLANES];
    logic                r_reload;
    logic [PLANES-1:0]   r_color;

    logic                w_ld;
    logic                w_pcnt_last;
    logic                w_xfer;
    logic                w_underflow;
    logic                w_grp_done;
    logic [WCNT_W-1:0]   w_wpg_m1;
    logic [2*WORD_W-1:0] w_win_nxt [PLANES];
    logic [WORD_W-1:0]   w_upper [PLANES];
    logic [PLANES-1:0]   w_bit;
    logic [PLANES-1:0]   w_color;

    assign w_ld        = bus.LOAD & ~r_load_q;
    assign w_pcnt_last = (r_pcnt == MAXIDX);
    // >= rather than == so a rez change mid-group can never strand wcnt
    assign w_grp_done  = w_ld & bus.DE & (r_wcnt >= w_wpg_m1);

    always_comb begin
        case (rez)
            2'b00:   w_wpg_m1 = WCNT_W'(PLANES - 1);
            2'b01:   w_wpg_m1 = WCNT_W'(WPG_MID - 1);
            default: w_wpg_m1 = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_underflow = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.pixClkEn && r_grp_rdy) begin
                    w_state_nxt = ST_RUN;
                    w_xfer      = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.pixClkEn && w_pcnt_last) begin
                    if (r_grp_rdy) begin
                        w_xfer = 1'b1;
                    end else if (bus.DE) begin
                        w_underflow = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pixel is taken from the post-shift window so scroll 0 shows a group WORD_W pixels after transfer
    always_comb begin
        for (int p = 0; p < PLANES; p++) begin
            w_win_nxt[p] = r_win[p];
            if (bus.pixClkEn) begin
                w_win_nxt[p] = {r_win[p][2*WORD_W-2:0], 1'b0};
                if (w_xfer) begin
                    w_win_nxt[p][WORD_W-1:0] = (WCNT_W'(p) <= w_wpg_m1) ? r_latch[p] : '0;
                end else if (w_underflow) begin
                    w_win_nxt[p][WORD_W-1:0] = '0;
                end
            end
            w_upper[p] = w_win_nxt[p][2*WORD_W-1:WORD_W];
            w_bit[p]   = w_upper[p][MAXIDX - r_scroll_q];
        end
    end

    always_comb begin
        w_color = '0;
        for (int p = 0; p < PLANES; p++) begin
            w_color[p] = (WCNT_W'(p) <= w_wpg_m1) ? w_bit[p] : 1'b0;
        end
        if (rez[1]) begin
            w_color[0] = w_bit[0] ^ monocolor;
        end
    end

    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            r_load_q   <= 1'b0;
            r_wcnt     <= '0;
            r_grp_rdy  <= 1'b0;
            r_pcnt     <= '0;
            r_scroll_q <= '0;
            r_reload   <= 1'b0;
            r_color    <= '0;
            for (int p = 0; p < PLANES; p++) begin
                r_latch[p] <= '0;
                r_win[p]   <= '0;
            end
        end else begin
            r_load_q <= bus.LOAD;
            r_reload <= w_xfer;

            for (int p = 0; p < PLANES; p++) begin
                if (w_ld && bus.DE && (r_wcnt == WCNT_W'(p))) begin
                    r_latch[p] <= bus.DIN;
                end
                r_win[p] <= w_win_nxt[p];
            end

            if (!bus.DE) begin
                r_wcnt <= '0;
            end else if (w_ld) begin
                r_wcnt <= (r_wcnt >= w_wpg_m1) ? '0 : r_wcnt + WCNT_W'(1);
            end

            // A group completing in the slot cycle survives to the next slot
            if (w_xfer) begin
                r_grp_rdy <= 1'b0;
            end
            if (w_grp_done) begin
                r_grp_rdy <= 1'b1;
            end

            if (r_state == ST_IDLE) begin
                r_pcnt <= '0;
            end else if (bus.pixClkEn) begin
                r_pcnt <= r_pcnt + SCROLL_W'(1);
            end

            if (w_xfer) begin
                r_scroll_q <= hscroll;
            end

            if (bus.pixClkEn) begin
                r_color <= w_color;
            end
        end
    end

`ifdef SHIFTER_UNDERFLOW_STAT_EN
    logic [7:0] r_ucnt;

    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            r_ucnt <= 8'd0;
        end else if (w_underflow && (r_ucnt != 8'hFF)) begin
            r_ucnt <= r_ucnt + 8'd1;
        end
    end

    assign underflow_cnt = r_ucnt;
`else
    assign underflow_cnt = 8'd0;
`endif

    assign Reload      = r_reload;
    assign color_index = r_color;

endmodule

// File: tb/tb_shifter_video_ste.sv
// Directed bench for shifter_video_ste: low/mid/high rez, hscroll, underflow, async reset.
module tb_shifter_video_ste;

    logic       clk32 = 1'b0;
    logic       nReset;
    logic [1:0] rez;
    logic       monocolor;
    logic [3:0] hscroll;
    logic       Reload;
    logic [3:0] color_index;
    logic [7:0] underflow_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

`ifdef SHIFTER_UNDERFLOW_STAT_EN
    localparam logic [7:0] UF1 = 8'd1;
`else
    localparam logic [7:0] UF1 = 8'd0;
`endif

    shifter_video_ste_if #(.WORD_W(16)) bus ();

    shifter_video_ste #(.PLANES(4), .WORD_W(16), .SCROLL_W(4)) dut (
        .clk32         (clk32),
        .nReset        (nReset),
        .bus           (bus),
        .rez           (rez),
        .monocolor     (monocolor),
        .hscroll       (hscroll),
        .Reload        (Reload),
        .color_index   (color_index),
        .underflow_cnt (underflow_cnt)
    );

    always #8 clk32 = ~clk32;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk32);
        @(negedge clk32);
    endtask

    task automatic pix();
        bus.pixClkEn = 1'b1;
        cycle();
        bus.pixClkEn = 1'b0;
    endtask

    task automatic ld_word(input logic [15:0] d);
        bus.DIN  = d;
        bus.LOAD = 1'b1;
        cycle();
        bus.LOAD = 1'b0;
        cycle();
    endtask

    initial begin
        nReset       = 1'b0;
        bus.pixClkEn = 1'b0;
        bus.DE       = 1'b0;
        bus.LOAD     = 1'b0;
        bus.DIN      = '0;
        rez          = 2'b00;
        monocolor    = 1'b0;
        hscroll      = 4'd0;
        repeat (3) cycle();
        check("rst_color", 32'(color_index), 32'h0);
        check("rst_reload", 32'(Reload), 32'h0);
        check("rst_ucnt", 32'(underflow_cnt), 32'h0);
        nReset = 1'b1;
        cycle();

        // Low rez, group A with hscroll 0
        bus.DE = 1'b1;
        ld_word(16'h8000); ld_word(16'h0000); ld_word(16'h0000); ld_word(16'h0000);
        pix();
        check("t1_reload_entry", 32'(Reload), 32'h1);
        for (int k = 1; k <= 16; k++) begin
            if (k == 2) begin
                ld_word(16'h8000); ld_word(16'h0000); ld_word(16'h0000); ld_word(16'h0000);
                hscroll = 4'd3;
            end
            pix();
            check($sformatf("t1_pix%0d", k), 32'(color_index), (k == 16) ? 32'h1 : 32'h0);
            if (k == 1) check("t1_reload_pulse", 32'(Reload), 32'h0);
        end
        check("t2_reload_slot", 32'(Reload), 32'h1);

        // Group B with hscroll 3; mid-group change to 7 must not take effect
        for (int k = 1; k <= 16; k++) begin
            if (k == 2) hscroll = 4'd7;
            if (k == 3) begin
                ld_word(16'hFFFF); ld_word(16'hFFFF); ld_word(16'hFFFF);
            end
            if (k == 16) hscroll = 4'd3;
            pix();
            check($sformatf("t2_pix%0d", k), 32'(color_index), (k == 13) ? 32'h1 : 32'h0);
        end
        check("t5_reload_uf", 32'(Reload), 32'h0);
        check("t5_ucnt", 32'(underflow_cnt), 32'(UF1));

        for (int k = 1; k <= 16; k++) begin
            pix();
            if (k == 1) bus.DE = 1'b0;
            check($sformatf("t5_zero%0d", k), 32'(color_index), 32'h0);
        end
        cycle();
        check("t5_ucnt_idle", 32'(underflow_cnt), 32'(UF1));

        // Mid rez: plane0 all ones, plane2 latch holds stale 0xFFFF
        rez     = 2'b01;
        hscroll = 4'd0;
        bus.DE  = 1'b1;
        ld_word(16'hFFFF); ld_word(16'h0000);
        pix();
        check("t3_reload_entry", 32'(Reload), 32'h1);
        for (int k = 1; k <= 32; k++) begin
            pix();
            if (k == 1) bus.DE = 1'b0;
            check($sformatf("t3_pix%0d", k), 32'(color_index),
                  (k >= 16 && k <= 31) ? 32'h1 : 32'h0);
        end

        // High rez, inverted mono
        rez       = 2'b10;
        monocolor = 1'b1;
        bus.DE    = 1'b1;
        ld_word(16'hAAAA);
        pix();
        check("t4_reload_entry", 32'(Reload), 32'h1);
        check("t4_pre_group", 32'(color_index), 32'h1);
        for (int k = 1; k <= 23; k++) begin
            pix();
            if (k == 1) bus.DE = 1'b0;
            if (k >= 16) check($sformatf("t4_pix%0d", k), 32'(color_index), 32'(k & 1));
        end

        // Async reset mid-group
        rez       = 2'b00;
        monocolor = 1'b0;
        bus.DE    = 1'b1;
        ld_word(16'h1234); ld_word(16'h5678);
        #3 nReset = 1'b0;
        #1;
        check("t6_rst_color", 32'(color_index), 32'h0);
        check("t6_rst_reload", 32'(Reload), 32'h0);
        check("t6_rst_ucnt", 32'(underflow_cnt), 32'h0);
        cycle();
        cycle();
        nReset = 1'b1;
        cycle();
        ld_word(16'h8000); ld_word(16'h8000); ld_word(16'h0000); ld_word(16'h8000);
        pix();
        check("t6_reload_entry", 32'(Reload), 32'h1);
        for (int k = 1; k <= 16; k++) begin
            pix();
            if (k >= 15) check($sformatf("t6_pix%0d", k), 32'(color_index),
                               (k == 16) ? 32'hB : 32'h0);
        end
        check("t6_ucnt_after", 32'(underflow_cnt), 32'(UF1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shifter_video_ste.md
Name: shifter_video_ste

Overview:
- Parametrised successor to the ST pixel shifter, run from the 32 MHz system clock.
- Collects bitplane words from the video bus into a plane latch bank.
- Transfers complete groups into per-plane 32-bit shift windows and emits a PLANES-wide color index per pixel enable.
- Adds STe-style fine horizontal scroll (0–15 pixel offset), configurable plane count, and explicit underflow handling.
- Sits between the MMU/video DMA word stream and the palette lookup.

Parameters:
- PLANES, 4, number of bitplanes; legal values 1, 2, 4, 8.
- WORD_W, 16, bits per bitplane word; also the pixels per group.
- SCROLL_W, 4, hscroll width; must equal log2(WORD_W).

Ports:
- clk32  in  1  system clock, 32 MHz, all logic on posedge
- nReset  in  1  asynchronous active-low reset
- pixClkEn  in  1  one-cycle pixel strobe; the external divider sets the rate per rez
- DE  in  1  display enable
- LOAD  in  1  word-valid strobe, level; a rising edge captures DIN
- rez  in  2  00 low, 01 mid, 1x high
- monocolor  in  1  invert the mono pixel in high rez
- DIN  in  WORD_W  bitplane word
- hscroll  in  SCROLL_W  fine scroll offset in pixels
- Reload  out  1  one-clk32 pulse when a group is transferred to the windows
- color_index  out  PLANES  registered pixel index
- underflow_cnt  out  8  saturating underflow count (optional feature)

Behaviour:
- Reset:
  - All latches, windows, counters, Reload, color_index and underflow_cnt are 0.
  - Internal state: state=IDLE, scroll_q=0.
- Load event:
  - ld = LOAD & ~LOAD_q, where LOAD_q is registered on clk32.
  - Exactly one event per rising edge, regardless of pixClkEn.
- Words per group (WPG): low = PLANES; mid = max(PLANES/2, 1); high = 1.
- On ld:
  - latch[wcnt] <= DIN.
  - If wcnt == WPG-1: wcnt <= 0 and grp_rdy <= 1. Otherwise wcnt++.
- DE low: wcnt <= 0 and any partial group is discarded. grp_rdy is retained.
- ld with DE low: the word is ignored.
- Pixel counter pcnt (SCROLL_W bits):
  - Advances only on pixClkEn while state=RUN.
  - Held at 0 in IDLE.
- States:
  - IDLE -> RUN: on pixClkEn with grp_rdy=1. Immediately perform a transfer.
  - RUN -> IDLE: at a transfer slot with grp_rdy=0 and DE=0. The windows still shift out remaining pixels.
- Transfer slot = pixClkEn & (pcnt == WORD_W-1), or the IDLE->RUN entry. In the slot:
  - win[p][WORD_W-1:0] <= latch[p] for active planes; inactive planes load 0.
  - grp_rdy <= 0.
  - scroll_q <= hscroll.
  - Reload=1 for that clk32 cycle only.
- Same-cycle grp_rdy set and transfer slot: the new group is NOT transferred (no bypass); the slot counts as an underflow.
- Underflow: a transfer slot in RUN with grp_rdy=0 and DE=1. The windows load 0 and Reload stays 0.
- Every pixClkEn: win[p] <= {win[p][2*WORD_W-2:0], 1'b0}, except that a transfer overwrites the low half in the same cycle.
- Pixel bit: bit[p] = win[p][2*WORD_W-1-scroll_q].
  - scroll_q=0 shows a group WORD_W pixels after its transfer.
  - hscroll is sampled only at transfer, so no mid-word tearing.
- color_index is registered on pixClkEn:
  - low: all PLANES bits.
  - mid: bits [WPG-1:0]; upper bits are 0.
  - high: index = {0..., bit[0] ^ monocolor}.
- Reset asserted mid-line: all state clears asynchronously. The first ld after release is latch[0].

Optional Feature:
- Macro: SHIFTER_UNDERFLOW_STAT_EN.
- Defined: underflow_cnt increments on each underflow, saturates at 255, and clears only on reset.
- Undefined: underflow_cnt is tied to 0 and no counter logic is generated.

Test Plan:
1. Low rez, PLANES=4, hscroll=0: four ld of 0x8000, 0, 0, 0, then 16 pixClkEn -> Reload at entry; pixel 16 after transfer has index 0x1, the others 0x0.
2. Same data, hscroll=3 -> the 0x1 pixel appears at pixel 13 after transfer; a hscroll change mid-group takes effect only at the next Reload.
3. Mid rez: two ld of 0xFFFF, 0x0000 -> index 0x1 for 16 pixels; bits [3:2] stay 0.
4. High rez, monocolor=1, ld 0xAAAA -> index[0] toggles 0,1,0,1... (inverted pattern); index[3:1]=0.
5. DE=1 but only 3 of 4 words before the slot -> underflow: Reload stays 0, 16 zero pixels follow, underflow_cnt=1 (0 without the macro).
6. nReset pulsed mid-group -> all outputs 0 immediately; the next 4 ld form a fresh group starting at latch[0].
